// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Instruction-fetch stage sitting in front of decode. Owns the PC, issues
// word-aligned requests to instruction memory, and holds one fetched
// instruction (with its PC and PC+4) in an output register for decode.
// A taken branch/jump from execute redirects the PC, flushes the output
// register and discards any fetch that is still in flight.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Once imem_req_valid is raised, it and imem_addr stay stable until
// accepted, unless a redirect arrives. Memory returns exactly one
// imem_resp_valid cycle per accepted request (no ready on the response side).
// inst_valid/inst_ready follow the same valid/ready rule toward decode.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   redirect_valid    execute has a resolved control transfer this cycle
//   branch            comparator result (taken = 1), qualified by redirect_valid
//   branch_target     redirect target address
//   imem_req_valid/imem_req_ready/imem_addr   fetch request channel
//   imem_resp_valid/imem_resp_data            fetch response channel
//   inst_valid/inst_ready/inst/inst_pc/inst_pc_plus4   output to decode
//   misaligned        one-cycle pulse: taken target had bits [1:0] != 0
//   dbg_state_o       current FSM state (0 = FETCH, 1 = WAIT)
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4,
  output logic        misaligned,
  output logic        dbg_state_o
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_WAIT  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        drop_q, drop_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_pc_plus4_q, inst_pc_plus4_d;
  logic        misaligned_q, misaligned_d;

  logic        take;
  logic        out_free;
  logic        accept;

  // Request side. A taken redirect suppresses the request so the old PC never
  // reaches memory; that is why a redirect in FETCH needs no drop.
  always_comb begin
    take           = redirect_valid && branch;
    out_free       = !inst_valid_q || inst_ready;
    imem_req_valid = !reset && (state_q == S_FETCH) && out_free && !take;
    imem_addr      = pc_q;
    accept         = imem_req_valid && imem_req_ready;
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    req_pc_d        = req_pc_q;
    drop_d          = drop_q;
    inst_valid_d    = inst_valid_q;
    inst_d          = inst_q;
    inst_pc_d       = inst_pc_q;
    inst_pc_plus4_d = inst_pc_plus4_q;
    misaligned_d    = take && (branch_target[1:0] != 2'b00);

    // Consume first; a load later in this block overrides it (load wins).
    if (inst_ready) begin
      inst_valid_d = 1'b0;
    end

    if (take) begin
      pc_d         = {branch_target[31:2], 2'b00};
      inst_valid_d = 1'b0;
      if (state_q == S_WAIT) begin
        if (imem_resp_valid) begin
          // The outstanding response arrives now and is thrown away here,
          // so nothing is left in flight to drop.
          drop_d  = 1'b0;
          state_d = S_FETCH;
        end else begin
          drop_d  = 1'b1;
        end
      end
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (accept) begin
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            state_d = S_FETCH;
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              inst_d          = imem_resp_data;
              inst_pc_d       = req_pc_q;
              inst_pc_plus4_d = req_pc_q + 32'd4;
              inst_valid_d    = 1'b1;
              pc_d            = req_pc_q + 32'd4;
            end
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_FETCH;
      pc_q            <= RESET_PC;
      req_pc_q        <= RESET_PC;
      // A request still in flight across reset will answer later; mark it so
      // that answer is discarded.
      drop_q          <= (state_q == S_WAIT) || accept;
      inst_valid_q    <= 1'b0;
      inst_q          <= 32'h0;
      inst_pc_q       <= 32'h0;
      inst_pc_plus4_q <= 32'h0;
      misaligned_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      req_pc_q        <= req_pc_d;
      drop_q          <= drop_d;
      inst_valid_q    <= inst_valid_d;
      inst_q          <= inst_d;
      inst_pc_q       <= inst_pc_d;
      inst_pc_plus4_q <= inst_pc_plus4_d;
      misaligned_q    <= misaligned_d;
    end
  end

  assign inst_valid    = inst_valid_q;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_pc_plus4 = inst_pc_plus4_q;
  assign misaligned    = misaligned_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Cycle-scripted bench. Each record gives the inputs for one clock cycle and
// the outputs expected during that cycle (before the next rising edge).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// imem_addr is compared only when a request is expected, and the instruction
// fields only when inst_valid is expected.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic        branch;
  logic [31:0] branch_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        misaligned;
  logic        dbg_state;

  int n_cmp;
  int n_fail;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .branch         (branch),
    .branch_target  (branch_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc_plus4  (inst_pc_plus4),
    .misaligned     (misaligned),
    .dbg_state_o    (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        rsv;
    logic [31:0] rsd;
    logic        ird;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic [31:0] e_ipc4;
    logic        e_mis;
  } vec_t;

  function automatic vec_t mk(input logic rst, rv, br, input logic [31:0] tgt,
                              input logic rdy, rsv, input logic [31:0] rsd,
                              input logic ird, e_rqv, input logic [31:0] e_addr,
                              input logic e_iv, input logic [31:0] e_inst,
                              input logic [31:0] e_ipc, e_ipc4, input logic e_mis);
    vec_t v;
    v.rst = rst; v.rv = rv; v.br = br; v.tgt = tgt; v.rdy = rdy;
    v.rsv = rsv; v.rsd = rsd; v.ird = ird;
    v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst;
    v.e_ipc = e_ipc; v.e_ipc4 = e_ipc4; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // driver: apply one cycle of inputs after the falling edge
  task automatic drive(input vec_t v);
    @(negedge clk);
    reset           = v.rst;
    redirect_valid  = v.rv;
    branch          = v.br;
    branch_target   = v.tgt;
    imem_req_ready  = v.rdy;
    imem_resp_valid = v.rsv;
    imem_resp_data  = v.rsd;
    inst_ready      = v.ird;
    #1;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    drive(v);
    cmp({nm, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, v.e_rqv});
    if (v.e_rqv) cmp({nm, ".addr"}, imem_addr, v.e_addr);
    cmp({nm, ".inst_valid"}, {31'b0, inst_valid}, {31'b0, v.e_iv});
    if (v.e_iv) begin
      cmp({nm, ".inst"}, inst, v.e_inst);
      cmp({nm, ".inst_pc"}, inst_pc, v.e_ipc);
      cmp({nm, ".inst_pc_plus4"}, inst_pc_plus4, v.e_ipc4);
    end
    cmp({nm, ".misaligned"}, {31'b0, misaligned}, {31'b0, v.e_mis});
  endtask

  vec_t tbl[27];
  vec_t wrap_seq[6];
  vec_t rst_seq[6];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset = 1'b1; redirect_valid = 1'b0; branch = 1'b0; branch_target = 32'h0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    inst_ready = 1'b1;

    // Main run from reset: sequential fetch, decode stall, redirects, memory
    // stall, misaligned target, branch=0 ignored, double redirect.
    //             rst rv br tgt           rdy rsv rsd           ird | rqv addr          iv inst          ipc           ipc4          mis
    tbl[0]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h0000_0000, 0, 32'h0,        32'h0,        32'h0,        0);
    tbl[1]  = mk(0, 0, 0, 32'h0,        1, 1, 32'h1111_0000, 1, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0);
    tbl[2]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h0000_0004, 1, 32'h1111_0000, 32'h0,       32'h4,        0);
    tbl[3]  = mk(0, 0, 0, 32'h0,        1, 1, 32'h1111_0004, 1, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0);
    tbl[4]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0,  0, 32'h0,         1, 32'h1111_0004, 32'h4,       32'h8,        0);
    tbl[5]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        0,  0, 32'h0,         1, 32'h1111_0004, 32'h4,       32'h8,        0);
    tbl[6]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h0000_0008, 1, 32'h1111_0004, 32'h4,       32'h8,        0);
    tbl[7]  = mk(0, 1, 1, 32'h100,      1, 0, 32'h0,        1,  0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0);
    tbl[8]  = mk(0, 0, 0, 32'h0,        1, 1, 32'h1111_0008, 1, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0);
    tbl[9]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h0000_0100, 0, 32'h0,        32'h0,        32'h0,        0);
    tbl[10] = mk(0, 0, 0, 32'h0,        1, 1, 32'hAAAA_0100, 1, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0);
    tbl[11] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1,  1, 32'h0000_0104, 1, 32'hAAAA_0100, 32'h100,     32'h104,      0);
    tbl[12] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1,  1, 32'h0000_0104, 0, 32'h0,        32'h0,        32'h0,        0);
    tbl[13] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h0000_0104, 0, 32'h0,        32'h0,        32'h0,        0);
    tbl[14] = mk(0, 1, 1, 32'h200,      1, 1, 32'hBBBB_0104, 1, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0);
    tbl[15] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h0000_0200, 0, 32'h0,        32'h0,        32'h0,        0);
    tbl[16] = mk(0, 0, 0, 32'h0,        1, 1, 32'hCCCC_0200, 0, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0);
    tbl[17] = mk(0, 1, 1, 32'h102,      1, 0, 32'h0,        0,  0, 32'h0,         1, 32'hCCCC_0200, 32'h200,     32'h204,      0);
    tbl[18] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h0000_0100, 0, 32'h0,        32'h0,        32'h0,        1);
    tbl[19] = mk(0, 1, 0, 32'h300,      1, 1, 32'hDDDD_0100, 1, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0);
    tbl[20] = mk(0, 1, 0, 32'h300,      1, 0, 32'h0,        1,  1, 32'h0000_0104, 1, 32'hDDDD_0100, 32'h100,     32'h104,      0);
    tbl[21] = mk(0, 1, 1, 32'h400,      1, 0, 32'h0,        1,  0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0);
    tbl[22] = mk(0, 1, 1, 32'h500,      1, 0, 32'h0,        1,  0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0);
    tbl[23] = mk(0, 0, 0, 32'h0,        1, 1, 32'hEEEE_0104, 1, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0);
    tbl[24] = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h0000_0500, 0, 32'h0,        32'h0,        32'h0,        0);
    tbl[25] = mk(0, 0, 0, 32'h0,        1, 1, 32'h5555_0500, 1, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0);
    tbl[26] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        1,  1, 32'h0000_0504, 1, 32'h5555_0500, 32'h500,     32'h504,      0);

    // PC wrap: run from 0xFFFF_FFF8 through 0xFFFF_FFFC to 0.
    wrap_seq[0] = mk(0, 1, 1, 32'hFFFF_FFF8, 1, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        32'h0,         32'h0,         0);
    wrap_seq[1] = mk(0, 0, 0, 32'h0,         1, 0, 32'h0,        1, 1, 32'hFFFF_FFF8, 0, 32'h0,        32'h0,         32'h0,         0);
    wrap_seq[2] = mk(0, 0, 0, 32'h0,         1, 1, 32'h7777_0001, 1, 0, 32'h0,        0, 32'h0,        32'h0,         32'h0,         0);
    wrap_seq[3] = mk(0, 0, 0, 32'h0,         1, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 1, 32'h7777_0001, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0);
    wrap_seq[4] = mk(0, 0, 0, 32'h0,         1, 1, 32'h7777_0002, 1, 0, 32'h0,        0, 32'h0,        32'h0,         32'h0,         0);
    wrap_seq[5] = mk(0, 0, 0, 32'h0,         1, 0, 32'h0,        1, 1, 32'h0000_0000, 1, 32'h7777_0002, 32'hFFFF_FFFC, 32'h0000_0000, 0);

    // Reset while waiting on a response: the next response is dropped and
    // address 0 is fetched again before anything reaches decode.
    rst_seq[0] = mk(1, 0, 0, 32'h0, 1, 1, 32'h9999_9999, 1, 0, 32'h0,         0, 32'h0,        32'h0, 32'h0, 0);
    rst_seq[1] = mk(0, 0, 0, 32'h0, 1, 0, 32'h0,         1, 1, 32'h0000_0000, 0, 32'h0,        32'h0, 32'h0, 0);
    rst_seq[2] = mk(0, 0, 0, 32'h0, 1, 1, 32'h9999_0000, 1, 0, 32'h0,         0, 32'h0,        32'h0, 32'h0, 0);
    rst_seq[3] = mk(0, 0, 0, 32'h0, 1, 0, 32'h0,         1, 1, 32'h0000_0000, 0, 32'h0,        32'h0, 32'h0, 0);
    rst_seq[4] = mk(0, 0, 0, 32'h0, 1, 1, 32'h9999_0001, 1, 0, 32'h0,         0, 32'h0,        32'h0, 32'h0, 0);
    rst_seq[5] = mk(0, 0, 0, 32'h0, 1, 0, 32'h0,         1, 1, 32'h0000_0004, 1, 32'h9999_0001, 32'h0, 32'h4, 0);

    // Reset values: two reset cycles, check during the second.
    drive(mk(1, 0, 0, 32'h0, 1, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0));
    cmp("rst0.req_valid", {31'b0, imem_req_valid}, 32'h0);
    drive(mk(1, 0, 0, 32'h0, 1, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0));
    cmp("rst1.req_valid", {31'b0, imem_req_valid}, 32'h0);
    cmp("rst1.inst_valid", {31'b0, inst_valid}, 32'h0);
    cmp("rst1.inst", inst, 32'h0);
    cmp("rst1.inst_pc", inst_pc, 32'h0);
    cmp("rst1.inst_pc_plus4", inst_pc_plus4, 32'h0);
    cmp("rst1.misaligned", {31'b0, misaligned}, 32'h0);
    cmp("rst1.addr", imem_addr, 32'h0);
    cmp("rst1.state", {31'b0, dbg_state}, 32'h0);

    for (int i = 0; i < 27; i++) run_vec($sformatf("main%0d", i), tbl[i]);
    for (int i = 0; i < 6; i++)  run_vec($sformatf("wrap%0d", i), wrap_seq[i]);
    for (int i = 0; i < 6; i++)  run_vec($sformatf("midrst%0d", i), rst_seq[i]);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
